// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Funnels results from NR_REQ functional units onto one scoreboard write-back
// port. Each requester owns a one-entry holding buffer; buffered results are
// arbitrated and presented on a registered write-back port. The scoreboard
// never back-pressures, so only the requesters are throttled (via req_ready_o).
//
// Build option: define WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer). Default build is round-robin.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   flush_i         discard every pending result
//   req_valid_i     per-requester result valid
//   req_ready_o     per-requester accept (combinational from state and grant)
//   req_trans_id_i  per-requester transaction ID
//   req_data_i      per-requester result data
//   req_ex_valid_i  per-requester exception flag
//   wb_valid_o      registered write-back valid, one-cycle pulse per result
//   wb_trans_id_o   write-back transaction ID
//   wb_data_o       write-back data
//   wb_ex_valid_o   write-back exception flag
//   busy_o          any holding buffer occupied
module wb_port_arbiter #(
    parameter int unsigned NR_REQ        = 4,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [NR_REQ-1:0]                    req_valid_i,
    output logic [NR_REQ-1:0]                    req_ready_o,
    input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] req_trans_id_i,
    input  logic [NR_REQ-1:0][XLEN-1:0]          req_data_i,
    input  logic [NR_REQ-1:0]                    req_ex_valid_i,
    output logic                                 wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]             wb_trans_id_o,
    output logic [XLEN-1:0]                      wb_data_o,
    output logic                                 wb_ex_valid_o,
    output logic                                 busy_o
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [NR_REQ-1:0]                    buf_valid_q, buf_valid_d;
    logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] buf_tid_q;
    logic [NR_REQ-1:0][XLEN-1:0]          buf_data_q;
    logic [NR_REQ-1:0]                    buf_ex_q;

    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             wb_load;

`ifdef WB_ARB_FIXED_PRIO_EN
    // Lowest occupied index wins; higher indices may starve.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (!grant_valid && buf_valid_q[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // First occupied buffer at or after rr_ptr_q, wrapping at NR_REQ.
    always_comb begin : grant_rr
        int unsigned cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NR_REQ) begin
                cand = cand - NR_REQ;
            end
            if (!grant_valid && buf_valid_q[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer moves past the winner; explicit wrap covers non-power-of-2 NR_REQ.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid && !flush_i) begin
            if (grant_idx == IDX_W'(NR_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // A buffer can take a new result when empty or when it drains this cycle.
    always_comb begin
        for (int i = 0; i < NR_REQ; i++) begin
            req_ready_o[i] = !rst_i && !flush_i &&
                             (!buf_valid_q[i] || (grant_valid && grant_idx == IDX_W'(i)));
        end
    end

    // Flush beats everything; a refill beats the drain of the same buffer.
    always_comb begin
        buf_valid_d = buf_valid_q;
        if (flush_i) begin
            buf_valid_d = '0;
        end else begin
            if (grant_valid) begin
                buf_valid_d[grant_idx] = 1'b0;
            end
            for (int i = 0; i < NR_REQ; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) begin
                    buf_valid_d[i] = 1'b1;
                end
            end
        end
    end

    assign wb_load = grant_valid && !flush_i;
    assign busy_o  = |buf_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
        end
    end

    // Payload needs no reset; it is qualified by buf_valid_q.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_REQ; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) begin
                buf_tid_q[i]  <= req_trans_id_i[i];
                buf_data_q[i] <= req_data_i[i];
                buf_ex_q[i]   <= req_ex_valid_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_o    <= 1'b0;
            wb_trans_id_o <= '0;
            wb_data_o     <= '0;
            wb_ex_valid_o <= 1'b0;
        end else begin
            wb_valid_o <= wb_load;
            if (wb_load) begin
                wb_trans_id_o <= buf_tid_q[grant_idx];
                wb_data_o     <= buf_data_q[grant_idx];
                wb_ex_valid_o <= buf_ex_q[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed test-plan steps followed by random
// traffic, all compared each cycle against a queue-free behavioural model of
// the pending-result set and the last winner.
module tb_wb_port_arbiter;

    localparam int N  = 4;
    localparam int TW = 3;
    localparam int XL = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, flush;
    logic [N-1:0]          req_valid, req_ready, req_ex;
    logic [N-1:0][TW-1:0]  req_tid;
    logic [N-1:0][XL-1:0]  req_data;
    logic                  wb_valid, wb_ex, busy;
    logic [TW-1:0]         wb_tid;
    logic [XL-1:0]         wb_data;

    wb_port_arbiter #(
        .NR_REQ        (N),
        .TRANS_ID_BITS (TW),
        .XLEN          (XL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_trans_id_i (req_tid),
        .req_data_i     (req_data),
        .req_ex_valid_i (req_ex),
        .wb_valid_o     (wb_valid),
        .wb_trans_id_o  (wb_tid),
        .wb_data_o      (wb_data),
        .wb_ex_valid_o  (wb_ex),
        .busy_o         (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which requesters hold a result, their payload, and
    // where the next fair search starts.
    bit            m_live = 1'b0;
    bit            m_pend [N];
    logic [TW-1:0] m_tid  [N];
    logic [XL-1:0] m_data [N];
    bit            m_ex   [N];
    int            m_next = 0;
    bit            m_wbv  = 1'b0;
    logic [TW-1:0] m_wbt  = '0;
    logic [XL-1:0] m_wbd  = '0;
    bit            m_wbe  = 1'b0;

    // Observed values from the most recent sample point.
    logic          o_wbv, o_wbe, o_busy;
    logic [TW-1:0] o_wbt;
    logic [XL-1:0] o_wbd;
    logic [N-1:0]  o_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
`ifdef WB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (m_pend[i]) return i;
`else
        for (int k = 0; k < N; k++) if (m_pend[(m_next + k) % N]) return (m_next + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        g = pick();
        for (int i = 0; i < N; i++) r[i] = !rst && !flush && (!m_pend[i] || g == i);
        return r;
    endfunction

    function automatic logic any_pend();
        logic a;
        a = 1'b0;
        for (int i = 0; i < N; i++) a = a | m_pend[i];
        return a;
    endfunction

    task automatic sample_and_check();
        @(negedge clk);
        o_wbv = wb_valid; o_wbt = wb_tid; o_wbd = wb_data; o_wbe = wb_ex;
        o_busy = busy; o_ready = req_ready;
        if (m_live) begin
            chk("wb_valid", o_wbv, m_wbv);
            chk("wb_trans_id", o_wbt, m_wbt);
            chk("wb_data", o_wbd, m_wbd);
            chk("wb_ex_valid", o_wbe, m_wbe);
            chk("busy", o_busy, any_pend());
            chk("req_ready", o_ready, exp_ready());
        end
    endtask

    task automatic model_step();
        logic [N-1:0] rdy;
        int g;
        rdy = exp_ready();
        g   = pick();
        if (rst) begin
            m_live = 1'b1;
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_next = 0; m_wbv = 1'b0; m_wbt = '0; m_wbd = '0; m_wbe = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_wbv = 1'b0;
        end else begin
            if (g >= 0) begin
                m_wbv = 1'b1; m_wbt = m_tid[g]; m_wbd = m_data[g]; m_wbe = m_ex[g];
                m_pend[g] = 1'b0;
                m_next = (g + 1) % N;
            end else begin
                m_wbv = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    m_pend[i] = 1'b1; m_tid[i] = req_tid[i];
                    m_data[i] = req_data[i]; m_ex[i] = req_ex[i];
                end
            end
        end
    endtask

    task automatic cycle();
        sample_and_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle();
        req_tid = '0; req_data = '0; req_ex = '0;
        cycle(); cycle();
        rst = 1'b0;

        // Single request from requester 1: buffer next cycle, write-back after.
        req_valid = 4'b0010; req_tid[1] = 3'd5; req_data[1] = 64'hDEAD; req_ex[1] = 1'b0;
        cycle();
        chk("t1_ready", o_ready[1], 1'b1);
        idle();
        cycle();
        chk("t1_busy_on", o_busy, 1'b1);
        chk("t1_wb_early", o_wbv, 1'b0);
        cycle();
        chk("t1_wb_valid", o_wbv, 1'b1);
        chk("t1_wb_tid", o_wbt, 3'd5);
        chk("t1_wb_data", o_wbd, 64'hDEAD);
        chk("t1_busy_off", o_busy, 1'b0);
        cycle();
        chk("t1_wb_pulse", o_wbv, 1'b0);

        // All requesters valid every cycle: back-to-back 0,1,2,3,...
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < N; i++) req_tid[i] = TW'(i);
        req_valid = '1;
        cycle(); cycle();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) req_data[i] = {$urandom, $urandom};
            cycle();
            chk("rr_wb_valid", o_wbv, 1'b1);
            chk("rr_tid_seq", o_wbt, TW'(k % N));
            chk("rr_ready_onehot", o_ready, 4'b0001 << ((k + 1) % N));
        end
        idle();
        repeat (5) cycle();

        // Wrap: last grant to requester 2, then 0 and 3 contend -> 3 first.
        req_valid = 4'b0100; req_tid[2] = 3'd2;
        cycle(); idle(); cycle(); cycle(); cycle();
        req_valid = 4'b1001; req_tid[0] = 3'd6; req_tid[3] = 3'd7;
        cycle(); idle();
        cycle();
        cycle();
        chk("wrap_first_valid", o_wbv, 1'b1);
        chk("wrap_first_tid", o_wbt, 3'd7);
        cycle();
        chk("wrap_second_valid", o_wbv, 1'b1);
        chk("wrap_second_tid", o_wbt, 3'd6);
        cycle(); cycle();

        // Flush with buffers 0 and 2 full, coinciding with a grant.
        req_valid = 4'b0101; req_tid[0] = 3'd1; req_tid[2] = 3'd3;
        cycle(); idle();
        flush = 1'b1;
        cycle();
        chk("flush_ready_low", o_ready, 4'b0000);
        flush = 1'b0;
        cycle();
        chk("flush_busy", o_busy, 1'b0);
        chk("flush_wb_none", o_wbv, 1'b0);
        cycle();
        chk("flush_wb_none2", o_wbv, 1'b0);

        // Reset with three buffers full drops everything.
        req_valid = 4'b0111;
        for (int i = 0; i < N; i++) begin
            req_tid[i] = TW'($urandom); req_data[i] = {$urandom, $urandom}; req_ex[i] = 1'b1;
        end
        cycle(); idle();
        rst = 1'b1;
        cycle();
        chk("rst_ready_low", o_ready, 4'b0000);
        rst = 1'b0;
        cycle();
        chk("rst_wb_valid", o_wbv, 1'b0);
        chk("rst_wb_tid", o_wbt, 3'd0);
        chk("rst_wb_data", o_wbd, 64'd0);
        chk("rst_wb_ex", o_wbe, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        repeat (3) begin
            cycle();
            chk("rst_no_stale", o_wbv, 1'b0);
        end

`ifdef WB_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 starves 3 until it drops out.
        req_valid = 4'b1001; req_tid[0] = 3'd1; req_tid[3] = 3'd4;
        cycle(); cycle();
        repeat (6) begin
            cycle();
            chk("fp_only_req0", o_wbt, 3'd1);
        end
        idle();
        cycle(); cycle();
        cycle();
        chk("fp_req3_granted", o_wbt, 3'd4);
        cycle();
`endif

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_tid[i] = TW'($urandom); req_data[i] = {$urandom, $urandom};
                req_ex[i] = 1'($urandom);
            end
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0; idle();
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
